// File: rtl/instruction_encoder.sv
// Program-load engine: packs instruction field bundles into 8-bit words and writes them
// through a 4-entry FIFO to consecutive addresses. Optional XOR checksum: INSTR_ENC_CHECKSUM_EN.
module instruction_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_fmt,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rs,
    input  logic [1:0]        in_rt,
    input  logic [3:0]        in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
`ifdef INSTR_ENC_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, len_q, acc, count_nxt;
    logic [7:0]        fifo [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        occ, occ_nxt;
    logic              accept_start, active, push, pop;
    logic [7:0]        enc_word;

    // Both streams use valid/ready: a transfer happens on a cycle where valid && ready;
    // the producer holds its payload stable while valid is high and ready is low.
    assign accept_start = (state == IDLE) && start;
    assign active       = (state == LOAD) || (state == FLUSH);
    assign in_ready     = (state == LOAD) && (occ != 3'd4) && (acc < len_q);
    assign push         = in_valid && in_ready;
    assign mem_we       = active && (occ != 3'd0);
    assign pop          = mem_we && mem_ready;
    assign mem_wdata    = mem_we ? fifo[rd_ptr] : 8'h00;
    assign mem_addr     = base + count;
    assign busy         = active;
    assign done         = (state == DONE);
    assign dbg_state    = state;
    assign enc_word     = in_fmt ? {in_opcode, in_imm} : {in_opcode, in_rs, in_rt};
    assign count_nxt    = count + ADDR_W'(pop);
    assign occ_nxt      = occ + 3'(push) - 3'(pop);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            len_q  <= '0;
            acc    <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                base   <= start_addr;
                len_q  <= len;
                acc    <= '0;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 2'd1;
                    acc    <= acc + ADDR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                count <= count_nxt;
                occ   <= occ_nxt;
            end
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               checksum <= 8'h00;
        else if (accept_start) checksum <= 8'h00;
        else if (pop)          checksum <= checksum ^ mem_wdata;
    end
`endif

    // FLUSH looks at next-cycle occupancy/count so done lands the cycle after the last write.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : LOAD;
            LOAD:  if (push && (acc == len_q - ADDR_W'(1))) state_nxt = FLUSH;
            FLUSH: if ((occ_nxt == 3'd0) && (count_nxt == len_q)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder; write-side scoreboard on {addr, data}.
module tb_instruction_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_addr, len;
    logic       in_valid, in_ready, in_fmt;
    logic [3:0] in_opcode, in_imm;
    logic [1:0] in_rs, in_rt;
    logic       mem_we, mem_ready;
    logic [7:0] mem_addr, mem_wdata;
    logic       busy, done;
    logic [7:0] count;
    logic [1:0] dbg_state;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    instruction_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .count(count),
`ifdef INSTR_ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fmt;
        logic [3:0] op;
        logic [1:0] rs, rt;
        logic [3:0] imm;
        logic [7:0] word;
    } bundle_t;

    bundle_t     stim_q[$];
    int          stim_idx;
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unused fields are filled with noise; the expected word is hand-computed by the caller.
    task automatic add_reg(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                           input logic [7:0] word);
        bundle_t b;
        b.fmt = 1'b0; b.op = op; b.rs = rs; b.rt = rt;
        b.imm = 4'($urandom_range(0, 15)); b.word = word;
        stim_q.push_back(b);
    endtask

    task automatic add_imm(input logic [3:0] op, input logic [3:0] imm, input logic [7:0] word);
        bundle_t b;
        b.fmt = 1'b1; b.op = op; b.imm = imm;
        b.rs = 2'($urandom_range(0, 3)); b.rt = 2'($urandom_range(0, 3)); b.word = word;
        stim_q.push_back(b);
    endtask

    task automatic new_stim();
        stim_q.delete();
        stim_idx = 0;
    endtask

    task automatic start_load(input logic [7:0] addr, input logic [7:0] l);
        start = 1'b1; start_addr = addr; len = l;
        tick();
        start = 1'b0;
    endtask

    // One cycle of offering the current bundle; the scoreboard learns of it only if taken.
    task automatic offer(input logic [7:0] base, inout int stalls);
        if (stim_idx < stim_q.size()) begin
            in_valid  = 1'b1;
            in_fmt    = stim_q[stim_idx].fmt;
            in_opcode = stim_q[stim_idx].op;
            in_rs     = stim_q[stim_idx].rs;
            in_rt     = stim_q[stim_idx].rt;
            in_imm    = stim_q[stim_idx].imm;
            if (in_ready) begin
                exp_q.push_back({base + 8'(stim_idx), stim_q[stim_idx].word});
                stim_idx++;
            end else begin
                stalls++;
            end
        end else begin
            in_valid = 1'b0;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drive_all(input logic [7:0] base, output int stalls);
        int budget = 200;
        stalls = 0;
        while (stim_idx < stim_q.size() && budget > 0) begin
            offer(base, stalls);
            budget--;
        end
        if (budget == 0) check_eq("drive_timeout", stim_idx, stim_q.size());
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check_eq("done_seen", done, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            wr_seen++;
            if (exp_q.size() == 0) check_eq("unexpected_write", {16'h1, mem_addr, mem_wdata}, 32'h0);
            else check_eq("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stalls, iters;
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0;
        in_valid = 1'b0; in_fmt = 1'b0; in_opcode = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        mem_ready = 1'b0;
        tick(); tick();
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 8'h00);
        check_eq("rst_mem_wdata", mem_wdata, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_count", count, 8'h00);
        rst = 1'b0;
        tick();

        // Register format, single word
        new_stim();
        add_reg(4'hA, 2'd2, 2'd1, 8'hA9);
        start_load(8'h10, 8'd1);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_in_ready", in_ready, 1'b1);
        drive_all(8'h10, stalls);
        check_eq("t1_mem_we", mem_we, 1'b1);
        check_eq("t1_wdata", mem_wdata, 8'hA9);
        check_eq("t1_addr", mem_addr, 8'h10);
        mem_ready = 1'b1;
        wait_done(n);
        check_eq("t1_done_latency", n, 1);
        check_eq("t1_count", count, 8'd1);
        tick();
        check_eq("t1_done_pulse", done, 1'b0);
        check_eq("t1_idle_busy", busy, 1'b0);
        check_eq("t1_count_held", count, 8'd1);

        // Immediate format, streaming at one word per cycle
        new_stim();
        add_imm(4'h3, 4'hF, 8'h3F);
        add_imm(4'h0, 4'h0, 8'h00);
        add_imm(4'hC, 4'h5, 8'hC5);
        start_load(8'h00, 8'd3);
        drive_all(8'h00, stalls);
        check_eq("t2_stalls", stalls, 0);
        wait_done(n);
        check_eq("t2_done_latency", n, 1);
        check_eq("t2_count", count, 8'd3);
`ifdef INSTR_ENC_CHECKSUM_EN
        check_eq("t2_checksum", checksum, 8'hFA);
`endif
        tick();

        // Backpressure: 6 offered while memory stalls, only 4 fit
        new_stim();
        add_imm(4'h1, 4'h1, 8'h11);
        add_imm(4'h2, 4'h2, 8'h22);
        add_imm(4'h3, 4'h4, 8'h34);
        add_imm(4'h4, 4'h8, 8'h48);
        add_reg(4'h5, 2'd1, 2'd2, 8'h56);
        add_reg(4'h6, 2'd3, 2'd3, 8'h6F);
        mem_ready = 1'b0;
        start_load(8'h20, 8'd6);
        stalls = 0;
        for (int i = 0; i < 6; i++) offer(8'h20, stalls);
        check_eq("t3_accepted", stim_idx, 4);
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_in_ready_full", in_ready, 1'b0);
            check_eq("t3_mem_we_hold", mem_we, 1'b1);
            check_eq("t3_addr_stable", mem_addr, 8'h20);
            check_eq("t3_wdata_stable", mem_wdata, 8'h11);
            tick();
        end
        mem_ready = 1'b1;
        drive_all(8'h20, stalls);
        wait_done(n);
        check_eq("t3_count", count, 8'd6);
        tick();

        // Address wrap
        new_stim();
        add_reg(4'h1, 2'd3, 2'd0, 8'h1C);
        add_imm(4'h7, 4'h2, 8'h72);
        start_load(8'hFF, 8'd2);
        drive_all(8'hFF, stalls);
        wait_done(n);
        check_eq("t4_count", count, 8'd2);
        tick();

        // Zero length
        start_load(8'h40, 8'd0);
        check_eq("t5_done", done, 1'b1);
        check_eq("t5_mem_we", mem_we, 1'b0);
        check_eq("t5_in_ready", in_ready, 1'b0);
        check_eq("t5_count", count, 8'd0);
        tick();
        check_eq("t5_done_pulse", done, 1'b0);

        // Reset after 2 of 5 writes
        new_stim();
        add_imm(4'h9, 4'h1, 8'h91);
        add_imm(4'h9, 4'h2, 8'h92);
        add_imm(4'h9, 4'h3, 8'h93);
        add_imm(4'h9, 4'h4, 8'h94);
        add_imm(4'h9, 4'h5, 8'h95);
        start_load(8'h50, 8'd5);
        wr_seen = 0;
        iters = 0;
        stalls = 0;
        while (wr_seen < 2 && iters < 20) begin
            offer(8'h50, stalls);
            iters++;
        end
        check_eq("t6_writes_before_rst", wr_seen, 2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_eq("t6_in_ready", in_ready, 1'b0);
        check_eq("t6_mem_we", mem_we, 1'b0);
        check_eq("t6_mem_addr", mem_addr, 8'h00);
        check_eq("t6_mem_wdata", mem_wdata, 8'h00);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_done", done, 1'b0);
        check_eq("t6_count", count, 8'h00);
`ifdef INSTR_ENC_CHECKSUM_EN
        check_eq("t6_checksum", checksum, 8'h00);
`endif
        tick();
        check_eq("t6_no_write_in_rst", mem_we, 1'b0);
        rst = 1'b0;
        tick();
        new_stim();
        add_reg(4'hE, 2'd0, 2'd3, 8'hE3);
        add_imm(4'h2, 4'hB, 8'h2B);
        start_load(8'h60, 8'd2);
        drive_all(8'h60, stalls);
        wait_done(n);
        check_eq("t6_reload_count", count, 8'd2);
`ifdef INSTR_ENC_CHECKSUM_EN
        check_eq("t6_reload_checksum", checksum, 8'hC8);
`endif
        tick();

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
